// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single shared line memory.
// One transaction in flight at a time; D wins ties unless I has been starved.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_W       = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [2:0]        starve_q, starve_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_wins;

  // D normally wins; once I has watched LIMIT D grants go by, I gets the next slot.
  assign d_wins = d_req && !(i_req && (starve_q == LIMIT));

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          owner_d = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          if (!i_req)               starve_d = '0;
          else if (starve_q < LIMIT) starve_d = starve_q + 3'd1;
          state_d = ISSUE;
        end else if (i_req) begin
          owner_d  = OWN_I;
          we_d     = 1'b0;
          addr_d   = i_addr;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (!we_q) begin
            if (owner_q == OWN_D) d_rdata_d = mem_rdata;
            else                  i_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = (state_q == RESP) && (owner_q == OWN_I);
  assign d_ack     = (state_q == RESP) && (owner_q == OWN_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive D-side grants issued while i_req is pending.
REQ-002 Parameter LINE_W, default 128: cache-line width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  I-cache line-read request; held high until i_ack.
REQ-006 i_addr  input  32  I-side line address.
REQ-007 i_ack  output  1  one-cycle pulse; i_rdata valid this cycle.
REQ-008 i_rdata  output  LINE_W  I-side read line.
REQ-009 d_req  input  1  D-cache request; held high until d_ack.
REQ-010 d_we  input  1  1 = line write-back, 0 = line read.
REQ-011 d_addr  input  32  D-side line address.
REQ-012 d_wdata  input  LINE_W  D-side write line.
REQ-013 d_ack  output  1  one-cycle pulse; read data valid or write complete.
REQ-014 d_rdata  output  LINE_W  D-side read line.
REQ-015 mem_req  output  1  request to the shared backing memory.
REQ-016 mem_we  output  1  write enable to memory.
REQ-017 mem_addr  output  32  latched address.
REQ-018 mem_wdata  output  LINE_W  latched write line.
REQ-019 mem_ready  input  1  memory accepts the request this cycle.
REQ-020 mem_rvalid  input  1  read data valid or write done; one-cycle pulse.
REQ-021 mem_rdata  input  LINE_W  memory read line.
REQ-022 busy  output  1  high in any state other than IDLE.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-024 IDLE: any request pending -> grant, latch owner/addr/we/wdata, go to ISSUE; none pending -> stay in IDLE.
REQ-025 Priority: D over I; exception: if starve_cnt == STARVE_LIMIT and i_req is high, grant I.
REQ-026 starve_cnt (3 bits): +1 on each D grant while i_req is high; cleared on an I grant or on a D grant with i_req low; saturates at STARVE_LIMIT.
REQ-027 I-side grant always has mem_we = 0; D-side grant has mem_we = latched d_we.
REQ-028 ISSUE: mem_req = 1 with latched fields; mem_ready = 1 -> WAIT; else stay in ISSUE holding all fields.
REQ-029 WAIT: mem_req = 0; mem_rvalid = 1 -> capture mem_rdata into owner's rdata register on reads, go to RESP.
REQ-030 RESP: owner's ack = 1 for exactly one cycle -> IDLE; the other ack stays 0.
REQ-031 Requester drops req on the edge ending the ack cycle; arbiter samples req again only in IDLE.
REQ-032 Minimum latency: req sampled in IDLE at cycle 0 -> ack at cycle 3, given mem_ready at cycle 1 and mem_rvalid at cycle 2.
REQ-033 Request-input changes after the grant are ignored until the next IDLE.
REQ-034 d_rdata is updated only by D reads; i_rdata only by I reads; both hold their value otherwise.
REQ-035 mem_rvalid outside WAIT is ignored; mem_ready outside ISSUE is ignored.
REQ-036 Simultaneous i_req and d_req in IDLE resolve per REQ-025 in the same cycle; the loser keeps waiting with no ack.
REQ-037 At most one transaction is outstanding; i_ack and d_ack are never high together.

Reset
REQ-038 reset low -> immediately, independent of clk: state = IDLE, mem_req = 0, mem_we = 0, i_ack = 0, d_ack = 0, busy = 0, starve_cnt = 0, mem_addr = 0, mem_wdata = 0, i_rdata = 0, d_rdata = 0.
REQ-039 Reset asserted mid-transaction drops that transaction without an ack; a mem_rvalid arriving after reset release is ignored per REQ-035.

Verification
REQ-040 Single I read: i_req, i_addr = 0x100, mem_ready at cycle 1, mem_rvalid with data 0xA5..A5 at cycle 2 -> i_ack at cycle 3, i_rdata = 0xA5..A5, d_ack = 0.
REQ-041 Collision: i_req and d_req (d_we = 1, d_addr = 0x200) rise together -> D served first with mem_we = 1 and mem_addr = 0x200; I granted in the next IDLE.
REQ-042 Starvation: d_req held continuously with i_req high -> exactly 4 D grants, then I grant, then D grants resume.
REQ-043 Back-pressure: mem_ready low for 5 cycles -> mem_req, mem_addr and mem_wdata stable throughout ISSUE; busy = 1.
REQ-044 Reset during WAIT: reset low -> busy = 0 and mem_req = 0 asynchronously; a later mem_rvalid pulse produces no ack.
REQ-045 Input change after grant: d_addr changes from 0x300 to 0x400 during ISSUE -> mem_addr stays 0x300.
